// File: rtl/mmio_uart_tx_pkg.sv
// Shared types and constants for the memory-mapped UART transmitter.
// Latency: n/a (types, offsets and bit positions only).
// Backpressure: n/a.
//
// Config macro: MMIO_UART_PARITY_EN adds the PARITY state to the FSM enum.
package mmio_uart_tx_pkg;

  typedef logic [31:0] u32_t;
  typedef logic [3:0]  wrstb_t;

  // Byte offsets of the registers; only bits [3:2] are decoded.
  localparam logic [3:0] TXDATA_OFS  = 4'h0;
  localparam logic [3:0] STATUS_OFS  = 4'h4;
  localparam logic [3:0] DIVISOR_OFS = 4'h8;

  // STATUS bit positions.
  localparam int STAT_BUSY    = 0;
  localparam int STAT_FULL    = 1;
  localparam int STAT_EMPTY   = 2;
  localparam int STAT_OVF     = 3;
  localparam int STAT_PAR_EN  = 4;
  localparam int STAT_CNT_LSB = 8;
  localparam int STAT_CNT_W   = 4;

  // Word index of a register offset, as seen on addr[3:2].
  function automatic logic [1:0] reg_idx(input logic [3:0] ofs);
    return ofs[3:2];
  endfunction

`ifdef MMIO_UART_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_STOP   = 3'd3,
    ST_PARITY = 3'd4
  } uart_tx_state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3
  } uart_tx_state_t;
`endif

endpackage

// File: rtl/mmio_uart_tx_sync_fifo.sv
// sync_fifo: single-clock circular-buffer FIFO, shared by the UART TX and RX blocks.
// Latency: a pushed entry is visible on pop_dat the cycle after the push edge.
// Backpressure: push to a full FIFO is dropped unless a pop happens in the same cycle.
//
// Ports: clk, rst (sync, active-high), push/push_dat, pop/pop_dat (head of queue,
// combinational), full, empty, count (0..DEPTH). DEPTH must be a power of two >= 2.
module sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign pop_dat = mem[rd_ptr];

  // When full, a simultaneous pop frees the slot at the head; the write lands in
  // that slot at the same edge the head data is consumed.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the DMEM bus (TXDATA/STATUS/DIVISOR).
// Latency: byte written at edge N is popped at N+1; start bit appears on txd after N+1.
// Backpressure: none on the bus; pushes to a full FIFO are dropped and flag overflow.
//
// Ports: clk, rst (sync, active-high), sel (window decode from top), addr (only [3:2]
// decoded), wrdata, wrstb (all-zero = read/idle), rddata (combinational, 0 when !sel),
// txd (idle high), irq (FIFO empty and shifter idle).
// Config macro: MMIO_UART_PARITY_EN enables STATUS bit4 and an even-parity bit.
module mmio_uart_tx
  import mmio_uart_tx_pkg::*;
#(
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   sel,
  input  u32_t   addr,
  input  u32_t   wrdata,
  input  wrstb_t wrstb,
  output u32_t   rddata,
  output logic   txd,
  output logic   irq
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  // ---------------------------------------------------------------- bus decode
  logic       we;
  logic [1:0] reg_sel;
  logic       wr_txdata;
  logic       wr_status;
  logic       wr_div_lo;
  logic       wr_div_hi;

  assign we        = sel & (|wrstb);
  assign reg_sel   = addr[3:2];
  assign wr_txdata = we & wrstb[0] & (reg_sel == reg_idx(TXDATA_OFS));
  assign wr_status = we & wrstb[0] & (reg_sel == reg_idx(STATUS_OFS));
  assign wr_div_lo = we & wrstb[0] & (reg_sel == reg_idx(DIVISOR_OFS));
  assign wr_div_hi = we & wrstb[1] & (reg_sel == reg_idx(DIVISOR_OFS));

  // Bits of the bus this block never looks at.
  logic unused_bits;
  assign unused_bits = ^{addr[31:4], addr[1:0], wrdata[31:16]};

  // ---------------------------------------------------------------- TX FIFO
  logic          fifo_pop;
  logic [7:0]    fifo_dat;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (wr_txdata),
    .push_dat (wrdata[7:0]),
    .pop      (fifo_pop),
    .pop_dat  (fifo_dat),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  // ---------------------------------------------------------------- registers
  logic [15:0] divisor;
  logic        overflow;
  logic        par_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      divisor <= DEFAULT_DIV;
    end else begin
      if (wr_div_lo) divisor[7:0]  <= wrdata[7:0];
      if (wr_div_hi) divisor[15:8] <= wrdata[15:8];
    end
  end

  // A push to a full FIFO only counts as overflow when nothing leaves that cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (wr_txdata && fifo_full && !fifo_pop) begin
      overflow <= 1'b1;
    end else if (wr_status && wrdata[STAT_OVF]) begin
      overflow <= 1'b0;
    end
  end

`ifdef MMIO_UART_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      par_en <= 1'b0;
    end else if (wr_status) begin
      par_en <= wrdata[STAT_PAR_EN];
    end
  end
`else
  assign par_en = 1'b0;
`endif

  // ---------------------------------------------------------------- TX FSM
  uart_tx_state_t state_q, state_d;
  logic [15:0]    baud_cnt, cnt_d;
  logic [2:0]     bit_idx, idx_d;
  logic [7:0]     shreg, sh_d;
  logic           txd_d;
  logic [15:0]    period_m1;
  logic           bit_end;
`ifdef MMIO_UART_PARITY_EN
  logic           par_q, par_d;
`endif

  // A divisor of zero behaves like one clock per bit.
  assign period_m1 = (divisor == 16'd0) ? 16'd0 : (divisor - 16'd1);
  assign bit_end   = (baud_cnt == 16'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      txd      <= 1'b1;
    end else begin
      state_q  <= state_d;
      baud_cnt <= cnt_d;
      bit_idx  <= idx_d;
      shreg    <= sh_d;
      txd      <= txd_d;
    end
  end

`ifdef MMIO_UART_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) par_q <= 1'b0;
    else     par_q <= par_d;
  end
`endif

  // The counter reloads from DIVISOR at each bit start, so a DIVISOR write
  // only changes the period of the next bit.
  always_comb begin
    state_d  = state_q;
    cnt_d    = baud_cnt;
    idx_d    = bit_idx;
    sh_d     = shreg;
    fifo_pop = 1'b0;
`ifdef MMIO_UART_PARITY_EN
    par_d    = par_q;
`endif

    if (state_q != ST_IDLE && !bit_end) begin
      cnt_d = baud_cnt - 16'd1;
    end

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          sh_d     = fifo_dat;
          cnt_d    = period_m1;
          state_d  = ST_START;
`ifdef MMIO_UART_PARITY_EN
          par_d    = ^fifo_dat;
`endif
        end
      end
      ST_START: begin
        if (bit_end) begin
          cnt_d   = period_m1;
          idx_d   = 3'd0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          cnt_d = period_m1;
          if (bit_idx == 3'd7) begin
`ifdef MMIO_UART_PARITY_EN
            state_d = par_en ? ST_PARITY : ST_STOP;
`else
            state_d = ST_STOP;
`endif
          end else begin
            idx_d = bit_idx + 3'd1;
            sh_d  = {1'b0, shreg[7:1]};
          end
        end
      end
`ifdef MMIO_UART_PARITY_EN
      ST_PARITY: begin
        if (bit_end) begin
          cnt_d   = period_m1;
          state_d = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        // Returning to IDLE costs one cycle before the next pop.
        if (bit_end) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // txd is registered from the next state so it changes exactly with the FSM.
    case (state_d)
      ST_START:  txd_d = 1'b0;
      ST_DATA:   txd_d = sh_d[0];
`ifdef MMIO_UART_PARITY_EN
      ST_PARITY: txd_d = par_d;
`endif
      default:   txd_d = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------- outputs
  assign irq = fifo_empty & (state_q == ST_IDLE);

  u32_t status_word;

  always_comb begin
    status_word               = '0;
    status_word[STAT_BUSY]    = (state_q != ST_IDLE);
    status_word[STAT_FULL]    = fifo_full;
    status_word[STAT_EMPTY]   = fifo_empty;
    status_word[STAT_OVF]     = overflow;
    status_word[STAT_PAR_EN]  = par_en;
    status_word[STAT_CNT_LSB +: STAT_CNT_W] = STAT_CNT_W'(fifo_count);
  end

  always_comb begin
    rddata = '0;
    if (sel) begin
      case (reg_sel)
        reg_idx(STATUS_OFS):  rddata = status_word;
        reg_idx(DIVISOR_OFS): rddata = {16'h0000, divisor};
        default:              rddata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Testbench for mmio_uart_tx: register vectors from a table, then directed frame,
// overflow, reset-abort and parity sequences checked against a serial line monitor.
module tb_mmio_uart_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wrdata = '0;
  logic [3:0]  wrstb = '0;
  logic [31:0] rddata;
  logic        txd;
  logic        irq;

  int n_err = 0;
  int n_chk = 0;

  always #5 clk = ~clk;

  mmio_uart_tx dut (
    .clk    (clk),
    .rst    (rst),
    .sel    (sel),
    .addr   (addr),
    .wrdata (wrdata),
    .wrstb  (wrstb),
    .rddata (rddata),
    .txd    (txd),
    .irq    (irq)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ------------------------------------------------------------ line monitor
  int          mon_div = 4;
  bit          mon_par = 1'b0;
  logic [7:0]  rx_q[$];
  int          gap_q[$];
  logic        par_q[$];
  int          frame_err = 0;

  logic        m_act = 1'b0;
  logic        m_cur, m_bad, m_pbit;
  logic [7:0]  m_byte;
  int          m_k, m_cnt;
  int          m_idle = 0;

  always @(negedge clk) begin
    if (rst) begin
      m_act  = 1'b0;
      m_idle = 0;
    end else if (!m_act) begin
      if (txd === 1'b0) begin
        m_act = 1'b1; m_k = 0; m_cnt = 1; m_cur = 1'b0;
        m_byte = '0; m_bad = 1'b0; m_pbit = 1'b0;
      end else begin
        m_idle++;
      end
    end else begin
      if (m_cnt >= mon_div) begin
        m_k++;
        m_cnt = 1;
        m_cur = txd;
        if (m_k >= 1 && m_k <= 8) m_byte[m_k-1] = txd;
        if (mon_par && m_k == 9) m_pbit = txd;
        if (m_k == (mon_par ? 10 : 9) && txd !== 1'b1) m_bad = 1'b1;
      end else begin
        m_cnt++;
        if (txd !== m_cur) m_bad = 1'b1;
      end
    end
    if (m_act && m_k == (mon_par ? 10 : 9) && m_cnt >= mon_div) begin
      rx_q.push_back(m_byte);
      gap_q.push_back(m_idle);
      par_q.push_back(m_pbit);
      if (m_bad) frame_err++;
      m_act  = 1'b0;
      m_idle = 0;
    end
  end

  // ------------------------------------------------------------ bus helpers
  task automatic drive(input logic s, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] st);
    @(negedge clk);
    sel = s; addr = a; wrdata = d; wrstb = st;
  endtask

  task automatic bus_idle();
    sel = 1'b0; addr = '0; wrdata = '0; wrstb = '0;
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] st);
    drive(1'b1, a, d, st);
    @(negedge clk);
    bus_idle();
  endtask

  task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
    drive(1'b1, a, '0, 4'h0);
    #1 d = rddata;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus_idle();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic clear_rx();
    rx_q.delete(); gap_q.delete(); par_q.delete();
    frame_err = 0;
  endtask

  task automatic wait_rx(input int n, input int budget, input string tag);
    int c = 0;
    while (rx_q.size() < n && c < budget) begin
      @(negedge clk);
      c++;
    end
    chk(tag, rx_q.size(), n);
  endtask

  // ------------------------------------------------------------ vectors
  typedef struct packed {
    logic        sel;
    logic [31:0] addr;
    logic [31:0] wdat;
    logic [3:0]  strb;   // non-zero: write cycle; zero: read compared against exp
    logic [31:0] exp;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [NV];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic [7:0]  b55;
    logic [7:0]  exp_bytes [10];
    logic        exp_t, exp_b;
    int          txd_bad, busy_bad, low_cnt;

    vecs[0]  = '{1'b1, 32'h0000_0004, 32'h0,         4'h0, 32'h0000_0004};
    vecs[1]  = '{1'b1, 32'h0000_0008, 32'h0,         4'h0, 32'h0000_01B2};
    vecs[2]  = '{1'b1, 32'h0000_0000, 32'h0,         4'h0, 32'h0};
    vecs[3]  = '{1'b1, 32'h0000_000C, 32'h0,         4'h0, 32'h0};
    vecs[4]  = '{1'b1, 32'h0000_0008, 32'h0000_0300, 4'h2, 32'h0};
    vecs[5]  = '{1'b1, 32'h0000_0008, 32'h0,         4'h0, 32'h0000_03B2};
    vecs[6]  = '{1'b0, 32'h0000_0008, 32'h0000_FFFF, 4'hF, 32'h0};
    vecs[7]  = '{1'b1, 32'h0000_0008, 32'h0,         4'h0, 32'h0000_03B2};
    vecs[8]  = '{1'b0, 32'h0000_0008, 32'h0,         4'h0, 32'h0};
    vecs[9]  = '{1'b1, 32'h0000_000C, 32'hFFFF_FFFF, 4'hF, 32'h0};
    vecs[10] = '{1'b1, 32'h0000_000C, 32'h0,         4'h0, 32'h0};
    vecs[11] = '{1'b1, 32'h0000_0008, 32'h1234_5678, 4'h1, 32'h0};
    vecs[12] = '{1'b1, 32'h0000_0008, 32'h0,         4'h0, 32'h0000_0378};
    vecs[13] = '{1'b0, 32'h0000_0000, 32'h0000_0055, 4'h1, 32'h0};
    vecs[14] = '{1'b1, 32'h0000_0000, 32'h0000_0055, 4'h2, 32'h0};
    vecs[15] = '{1'b1, 32'h0000_0004, 32'h0,         4'h0, 32'h0000_0004};
    vecs[16] = '{1'b1, 32'h0000_0004, 32'hFFFF_FFEF, 4'hF, 32'h0};
    vecs[17] = '{1'b1, 32'h0000_0004, 32'h0,         4'h0, 32'h0000_0004};
    vecs[18] = '{1'b1, 32'h0000_0008, 32'h0000_0004, 4'h3, 32'h0};
    vecs[19] = '{1'b1, 32'h1000_000A, 32'h0,         4'h0, 32'h0000_0004};

    // ---------------- reset state
    do_reset();
    #1;
    chk("reset_txd", 32'(txd), 32'd1);
    chk("reset_irq", 32'(irq), 32'd1);
    chk("reset_rddata_unsel", rddata, 32'h0);

    // ---------------- register map table
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].sel, vecs[i].addr, vecs[i].wdat, vecs[i].strb);
      if (vecs[i].strb == 4'h0) begin
        #1 chk($sformatf("vec%0d", i), rddata, vecs[i].exp);
      end
    end
    @(negedge clk);
    bus_idle();

    // ---------------- single 0x55 frame at DIVISOR=4
    clear_rx();
    mon_div = 4;
    mon_par = 1'b0;
    b55 = 8'h55;
    txd_bad = 0;
    busy_bad = 0;
    bus_wr(32'h0, 32'h55, 4'h1);
    sel = 1'b1; addr = 32'h4; wrstb = 4'h0;
    for (int n = 1; n <= 42; n++) begin
      if (n > 1) @(negedge clk);
      #1;
      exp_t = (n < 2) ? 1'b1 : (n < 6) ? 1'b0 : (n < 38) ? b55[(n-6)/4] : 1'b1;
      exp_b = (n >= 2 && n <= 41);
      if (txd !== exp_t) txd_bad++;
      if (rddata[0] !== exp_b) busy_bad++;
      if (n == 1) chk("f55_irq_pending", 32'(irq), 32'd0);
    end
    chk("f55_txd_bad_samples", txd_bad, 0);
    chk("f55_busy_bad_samples", busy_bad, 0);
    chk("f55_irq_after", 32'(irq), 32'd1);
    chk("f55_status_after", rddata, 32'h4);
    bus_idle();
    wait_rx(1, 50, "f55_rx_count");
    if (rx_q.size() >= 1) chk("f55_rx_byte", 32'(rx_q[0]), 32'h55);

    // ---------------- overflow and push+pop on full at DIVISOR=1
    do_reset();
    clear_rx();
    mon_div = 1;
    bus_wr(32'h8, 32'h1, 4'h3);
    exp_bytes[0] = 8'hA0;
    for (int i = 1; i < 9; i++) exp_bytes[i] = 8'h30 + 8'(i - 1);
    exp_bytes[9] = 8'h39;
    drive(1'b1, 32'h0, 32'hA0, 4'h1);
    for (int i = 0; i < 9; i++) drive(1'b1, 32'h0, 32'h30 + i, 4'h1);
    // Clearing write: rddata still shows the pre-edge STATUS.
    drive(1'b1, 32'h4, 32'h8, 4'h1);
    #1 chk("ovf_status_set", rddata, 32'h0000_080B);
    drive(1'b1, 32'h4, 32'h0, 4'h0);
    #1 chk("ovf_status_cleared", rddata, 32'h0000_0803);
    drive(1'b1, 32'h0, 32'h39, 4'h1);
    drive(1'b1, 32'h4, 32'h0, 4'h0);
    #1 chk("full_push_pop", rddata, 32'h0000_0803);
    bus_idle();
    wait_rx(10, 800, "ovf_rx_count");
    for (int i = 0; i < 10; i++) begin
      if (i < rx_q.size()) begin
        chk($sformatf("ovf_rx_byte%0d", i), 32'(rx_q[i]), 32'(exp_bytes[i]));
        if (i > 0) chk($sformatf("ovf_gap%0d", i), gap_q[i], 1);
      end
    end
    chk("ovf_frame_err", frame_err, 0);
    bus_rd(32'h4, rd);
    chk("ovf_status_final", rd, 32'h4);
    chk("ovf_irq_final", 32'(irq), 32'd1);
    bus_idle();

    // ---------------- reset during DATA bit 3
    do_reset();
    clear_rx();
    mon_div = 4;
    bus_wr(32'h8, 32'h4, 4'h3);
    bus_wr(32'h0, 32'hF0, 4'h1);
    repeat (18) @(negedge clk);
    #1 chk("rst_mid_bit3_low", 32'(txd), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    #1 chk("rst_mid_txd_high", 32'(txd), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    bus_rd(32'h4, rd);
    chk("rst_mid_status", rd, 32'h4);
    bus_idle();
    low_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (txd !== 1'b1) low_cnt++;
    end
    chk("rst_mid_no_residual", low_cnt, 0);
    chk("rst_mid_rx_empty", rx_q.size(), 0);

    // ---------------- parity option
    do_reset();
    clear_rx();
    mon_div = 2;
    bus_wr(32'h8, 32'h2, 4'h3);
    bus_wr(32'h4, 32'h10, 4'h1);
`ifdef MMIO_UART_PARITY_EN
    bus_rd(32'h4, rd);
    chk("par_status_en", rd, 32'h14);
    bus_idle();
    mon_par = 1'b1;
    bus_wr(32'h0, 32'h07, 4'h1);
    bus_wr(32'h0, 32'h03, 4'h1);
    wait_rx(2, 200, "par_rx_count");
    if (rx_q.size() >= 2) begin
      chk("par_byte0", 32'(rx_q[0]), 32'h07);
      chk("par_bit0", 32'(par_q[0]), 32'd1);
      chk("par_byte1", 32'(rx_q[1]), 32'h03);
      chk("par_bit1", 32'(par_q[1]), 32'd0);
    end
`else
    bus_rd(32'h4, rd);
    chk("nopar_status", rd, 32'h4);
    bus_idle();
    mon_par = 1'b0;
    bus_wr(32'h0, 32'h07, 4'h1);
    wait_rx(1, 200, "nopar_rx_count");
    if (rx_q.size() >= 1) chk("nopar_byte", 32'(rx_q[0]), 32'h07);
`endif
    chk("par_frame_err", frame_err, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
- Memory-mapped UART transmitter. It is a responder on the MINA core's DMEM bus: addr, wrdata, wrstb, rddata.
- The top level decodes a peripheral window and drives sel. The block sits beside dmem0, and top muxes rddata between the two responders.
- The core writes bytes into a TX FIFO. A baud-rate shifter serialises them 8N1, LSB first, onto txd.

Parameters:
- FIFO_DEPTH, 8, TX FIFO entries; power of two, minimum 2.
- DEFAULT_DIV, 16'd434, reset value of the DIVISOR register (115200 baud at 50 MHz).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset. Synchronous, active-high.
- sel  in  1  peripheral window selected by top's address decode.
- addr  in  32 (u32_t)  byte address. Only addr[3:2] is decoded.
- wrdata  in  32 (u32_t)  write data.
- wrstb  in  4 (wrstb_t)  byte write strobes; all-zero means read or idle.
- rddata  out  32 (u32_t)  read data. Combinational from addr and state.
- txd  out  1  serial output. Idle high.
- irq  out  1  level interrupt: FIFO empty and shifter idle.

Behaviour:
- Write qualifier: we = sel & |wrstb. Reads have no side effects, because the bus has no read enable.
- Register map, selected by addr[3:2]:
  - 0 TXDATA: write with wrstb[0] pushes wrdata[7:0]. Reads as 0.
  - 1 STATUS, read-only except bit 3:
    - bit0 busy (shifter not IDLE)
    - bit1 full
    - bit2 empty
    - bit3 overflow (sticky; write 1 with wrstb[0] clears it)
    - bits[11:8] FIFO count
    - all other bits 0
  - 2 DIVISOR: bits[15:0], byte-granular via wrstb[1:0]. Reads back the value.
  - 3: reads 0, writes ignored.
- rddata is 0 when sel=0.
- Reset: FIFO flushed, count 0, overflow 0, DIVISOR=DEFAULT_DIV, FSM IDLE, txd=1, irq=1, rddata per map.
- A reset mid-frame forces txd=1 on the next edge and abandons the frame.
- Push to a full FIFO: the byte is dropped, overflow is set, count is unchanged.
- Push and pop in the same cycle on a full FIFO is a legal push; count stays unchanged and overflow is not set.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: if FIFO not empty, pop into shift register, go to START. The pop happens that cycle.
  - START: txd=0 for one bit period.
  - DATA: 8 bit periods, LSB first, bit index 0..7.
  - STOP: txd=1 for one bit period, then return to IDLE.
  - Back-to-back bytes: there is exactly one IDLE cycle between STOP end and the next START.
- Bit period = max(DIVISOR,1) clocks. The baud counter reloads from DIVISOR at each bit start, so a DIVISOR write takes effect at the next bit boundary.
- The FIFO uses a circular pointer with wrap-around. count is log2(FIFO_DEPTH)+1 bits wide.
- A STATUS read in the same cycle as a push shows the pre-edge values.

Optional Feature:
- MMIO_UART_PARITY_EN.
- Defined: STATUS bit4 is a R/W parity-enable, reset 0. When it is set, the FSM inserts a PARITY state between DATA and STOP, driving even parity (XOR of the 8 data bits) for one bit period.
- Undefined: no PARITY state, STATUS bit4 reads 0, frames are always 8N1.

Decomposition:
- Shared package (types): register offsets (TXDATA_OFS=0x0, STATUS_OFS=0x4, DIVISOR_OFS=0x8), STATUS bit positions, FSM state enum uart_tx_state_t. u32_t and wrstb_t are reused from the same package.
- One sub-module, sync_fifo: parameterised width and depth; push, pop, full, empty, count ports. It is reused later by an RX block.

Test Plan:
- Reset, then read STATUS -> rddata=0x00000004 (empty). DIVISOR reads 0x000001B2. txd=1, irq=1.
- Set DIVISOR=4, write TXDATA=0x55 -> txd low 4 clocks, then 0,1,0,1,... wait, LSB first: 1,0,1,0,1,0,1,0 each 4 clocks, then high 4 clocks. busy=1 during the frame; irq returns to 1 after STOP.
- Set DIVISOR=1, push 9 bytes while the shifter is busy -> 8 accepted, overflow=1. Writing STATUS=0x8 clears overflow. All 8 bytes are transmitted in order with a 1-cycle IDLE gap.
- Assert rst during DATA bit 3 -> txd=1 next edge. STATUS=0x4, and no residual frame follows.
- Write DIVISOR with wrstb=4'b0010 and wrdata=0x0000_0300 after reset -> DIVISOR reads 0x000003B2. With sel=0, writes are ignored and rddata=0.
- With MMIO_UART_PARITY_EN defined, set parity enable and send 0x07 -> a parity bit of 1 appears between bit7 and STOP.
